// File: rtl/aes_stream_host_if.sv
// Request/result stream between a client and aes_stream_host.
// The client drives the master side; the host implements the slave side.
interface aes_stream_host_if;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_key;
    logic [127:0] in_block;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_block;

    modport master (
        output in_valid, in_key, in_block, out_ready,
        input  in_ready, out_valid, out_block
    );

    modport slave (
        input  in_valid, in_key, in_block, out_ready,
        output in_ready, out_valid, out_block
    );
endinterface

// File: rtl/aes_stream_host.sv
// Feeds a 128-bit key/plaintext byte-serially into the AES core and collects the
// ciphertext. Define AES_HOST_TIMEOUT_EN to bound the wait for the core result.
module aes_stream_host #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic             clk,
    input  logic             rst_n,
    aes_stream_host_if.slave strm,
    output logic             busy,
    output logic             err,
    output logic             aes_enable,
    output logic [7:0]       aes_key_byte,
    output logic [7:0]       aes_state_byte,
    input  logic [7:0]       aes_state_out_byte,
    input  logic             aes_load,
    input  logic             aes_ready
);

    typedef enum logic [2:0] {IDLE, LOAD, WAIT, CAPT, DONE} hostState_t;

    // One counter serves the LOAD/CAPT byte positions and the WAIT timeout.
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam int CNT_W = (TMO_W > 5) ? TMO_W : 5;

    hostState_t       state, stateNext;
    logic [CNT_W-1:0] cnt, cntNext;
    logic [15:0][7:0] keyReg, keyNext;
    logic [15:0][7:0] blockReg, blockNext;
    logic [15:0][7:0] outBlockNext;
    logic             inReadyNext;
    logic             outValidNext;
    logic             busyNext;
    logic             enableNext;
    logic [7:0]       keyByteNext;
    logic [7:0]       stateByteNext;
    logic [3:0]       bytePos;
`ifdef AES_HOST_TIMEOUT_EN
    logic             errNext;
`endif

    assign bytePos = cnt[3:0];

    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves one
        // unassigned, which would otherwise infer a latch.
        stateNext     = state;
        cntNext       = cnt;
        keyNext       = keyReg;
        blockNext     = blockReg;
        outBlockNext  = strm.out_block;
        inReadyNext   = 1'b0;
        outValidNext  = 1'b0;
        enableNext    = 1'b0;
        keyByteNext   = 8'h00;
        stateByteNext = 8'h00;
`ifdef AES_HOST_TIMEOUT_EN
        errNext       = err;
`endif

        case (state)
            IDLE: begin
                inReadyNext = 1'b1;
                if (strm.in_valid && strm.in_ready) begin
                    stateNext     = LOAD;
                    cntNext       = '0;
                    keyNext       = strm.in_key;
                    blockNext     = strm.in_block;
                    inReadyNext   = 1'b0;
                    enableNext    = 1'b1;
                    keyByteNext   = strm.in_key[127:120];
                    stateByteNext = strm.in_block[127:120];
                end
            end

            // Byte 0 shows in L0 and L1, byte n in L(n+1); L16 is the last cycle.
            LOAD: begin
                enableNext = 1'b1;
                if (cnt == CNT_W'(16)) begin
                    stateNext = WAIT;
                    cntNext   = '0;
                end else begin
                    keyByteNext   = keyReg[4'd15 - bytePos];
                    stateByteNext = blockReg[4'd15 - bytePos];
                    cntNext       = cnt + CNT_W'(1);
                end
            end

            WAIT: begin
                enableNext = 1'b1;
                if (aes_ready && !aes_load) begin
                    stateNext = CAPT;
                    cntNext   = '0;
                end
`ifdef AES_HOST_TIMEOUT_EN
                else if (cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    stateNext   = IDLE;
                    cntNext     = '0;
                    errNext     = 1'b1;
                    enableNext  = 1'b0;
                    inReadyNext = 1'b1;
                end else begin
                    cntNext = cnt + CNT_W'(1);
                end
`endif
            end

            // Always 16 bytes, whatever aes_ready does after R0.
            CAPT: begin
                enableNext = 1'b1;
                outBlockNext[4'd15 - bytePos] = aes_state_out_byte;
                if (cnt == CNT_W'(15)) begin
                    stateNext    = DONE;
                    cntNext      = '0;
                    enableNext   = 1'b0;
                    outValidNext = 1'b1;
                end else begin
                    cntNext = cnt + CNT_W'(1);
                end
            end

            DONE: begin
                outValidNext = 1'b1;
                if (strm.out_ready) begin
                    stateNext    = IDLE;
                    outValidNext = 1'b0;
                    inReadyNext  = 1'b1;
                end
            end

            default: begin
                stateNext = IDLE;
                cntNext   = '0;
            end
        endcase

        busyNext = (stateNext != IDLE);
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state          <= IDLE;
            cnt            <= '0;
            strm.in_ready  <= 1'b0;
            strm.out_valid <= 1'b0;
            strm.out_block <= '0;
            busy           <= 1'b0;
            aes_enable     <= 1'b0;
            aes_key_byte   <= 8'h00;
            aes_state_byte <= 8'h00;
        end else begin
            state          <= stateNext;
            cnt            <= cntNext;
            strm.in_ready  <= inReadyNext;
            strm.out_valid <= outValidNext;
            strm.out_block <= outBlockNext;
            busy           <= busyNext;
            aes_enable     <= enableNext;
            aes_key_byte   <= keyByteNext;
            aes_state_byte <= stateByteNext;
        end
    end

    // NOTE: the operand registers carry no reset; they are only read after being
    // loaded on an accepted request.
    always_ff @(posedge clk) begin
        keyReg   <= keyNext;
        blockReg <= blockNext;
    end

`ifdef AES_HOST_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err <= 1'b0;
        end else begin
            err <= errNext;
        end
    end
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_aes_stream_host.sv
// Directed bench for aes_stream_host with a byte-serial core model that answers the
// FIPS-197 vectors. Compile with AES_HOST_TIMEOUT_EN to exercise the WAIT timeout.
`timescale 1ns/1ps
module tb_aes_stream_host;
    localparam logic [127:0] K1 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] P1 = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C1 = 128'h69c4e0d86a7b0432d8cdb78070b4c55a;
    localparam logic [127:0] K2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] P2 = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] C2 = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam int PROC = 6;  // core busy cycles between end of LOAD and R0
`ifdef AES_HOST_TIMEOUT_EN
    localparam int TMO = 40;
`else
    localparam int TMO = 255;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       busy, err, aes_enable;
    logic [7:0] aes_key_byte, aes_state_byte;
    logic [7:0] aes_state_out_byte = 8'h00;
    logic       aes_load = 1'b0;
    logic       aes_ready = 1'b0;

    aes_stream_host_if strm();

    aes_stream_host #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rst_n(rst_n), .strm(strm), .busy(busy), .err(err),
        .aes_enable(aes_enable), .aes_key_byte(aes_key_byte), .aes_state_byte(aes_state_byte),
        .aes_state_out_byte(aes_state_out_byte), .aes_load(aes_load), .aes_ready(aes_ready)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Core model: samples bytes in L1..L16, answers from a vector table.
    logic         neverReady = 1'b0;
    logic         dropReady = 1'b0;
    int           coreCyc = 0;
    logic [127:0] capKey = '0;
    logic [127:0] capBlk = '0;
    logic [127:0] coreCt = '0;

    function automatic logic [127:0] refCipher(input logic [127:0] k, input logic [127:0] p);
        if (k == K1 && p == P1) return C1;
        if (k == K2 && p == P2) return C2;
        return '0;
    endfunction

    always @(negedge clk) begin
        int pos;
        if (!aes_enable) begin
            coreCyc = 0;
            aes_load = 1'b0;
            aes_ready = 1'b0;
            aes_state_out_byte = 8'h00;
        end else begin
            if (coreCyc >= 1 && coreCyc <= 16) begin
                capKey[8*(16-coreCyc) +: 8] = aes_key_byte;
                capBlk[8*(16-coreCyc) +: 8] = aes_state_byte;
            end
            if (coreCyc < 17 + PROC) begin
                aes_load = 1'b1;
                aes_ready = !neverReady && (coreCyc == 19 || coreCyc == 20);
                aes_state_out_byte = 8'h00;
            end else if (coreCyc == 17 + PROC) begin
                coreCt = refCipher(capKey, capBlk);
                aes_load = 1'b0;
                aes_ready = !neverReady;
            end else if (coreCyc <= 17 + PROC + 16) begin
                pos = coreCyc - (18 + PROC);
                aes_load = 1'b0;
                aes_ready = !neverReady && !(dropReady && pos >= 5 && pos <= 8);
                aes_state_out_byte = coreCt[8*(15-pos) +: 8];
            end else begin
                aes_load = 1'b0;
                aes_ready = 1'b0;
                aes_state_out_byte = 8'h00;
            end
            coreCyc++;
        end
    end

    // Monitor: enable run lengths, gaps between operations, result handshakes.
    int           enRun = 0, lastEnRun = 0, gapRun = 0, minGap = 1000, ovRises = 0;
    logic         gapValid = 1'b0, prevOv = 1'b0;
    logic [127:0] results[$];

    always @(negedge clk) begin
        if (aes_enable) begin
            if (gapRun > 0) begin
                if (gapValid && gapRun < minGap) minGap = gapRun;
                gapRun = 0;
                gapValid = 1'b1;
            end
            enRun++;
        end else begin
            if (enRun > 0) begin
                lastEnRun = enRun;
                enRun = 0;
            end
            gapRun++;
        end
        if (strm.out_valid && !prevOv) ovRises++;
        prevOv = strm.out_valid;
        if (strm.out_valid && strm.out_ready) results.push_back(strm.out_block);
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Called at posedge+1; returns at posedge+1 of L0 with the inputs scrambled.
    task automatic sendReq(input logic [127:0] k, input logic [127:0] b);
        int n = 0;
        strm.in_valid = 1'b1;
        strm.in_key = k;
        strm.in_block = b;
        while (strm.in_ready !== 1'b1 && n < 300) begin
            tick(1);
            n++;
        end
        if (n >= 300) check("accept wait expired", 128'd0, 128'd1);
        tick(1);
        strm.in_valid = 1'b0;
        strm.in_key = ~k;
        strm.in_block = ~b;
    endtask

    task automatic waitValid(input int budget);
        int n = 0;
        while (strm.out_valid !== 1'b1 && n < budget) begin
            tick(1);
            n++;
        end
        if (strm.out_valid !== 1'b1) check("out_valid wait expired", 128'd0, 128'd1);
    endtask

    task automatic takeResult();
        strm.out_ready = 1'b1;
        tick(1);
        strm.out_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0]   kb [18];
        logic [7:0]   sb [18];
        logic [127:0] expB2b [4];
        int           ovBefore;
        int           n;

        strm.in_valid = 1'b0;
        strm.in_key = '0;
        strm.in_block = '0;
        strm.out_ready = 1'b0;

        // Reset values and in_ready release timing
        tick(3);
        check("reset flags", 128'({strm.in_ready, strm.out_valid, busy, err, aes_enable}), 128'd0);
        check("reset bytes", 128'({aes_key_byte, aes_state_byte}), 128'd0);
        check("reset out_block", strm.out_block, 128'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("in_ready before release edge", 128'(strm.in_ready), 128'd0);
        tick(1);
        check("in_ready after release", 128'(strm.in_ready), 128'd1);

        // FIPS-197 C.1 with byte timing
        sendReq(K1, P1);
        for (int i = 0; i < 18; i++) begin
            @(negedge clk);
            kb[i] = aes_key_byte;
            sb[i] = aes_state_byte;
            if (i == 0) check("L0 busy/in_ready", 128'({busy, strm.in_ready}), 128'b10);
        end
        check("key byte L0", 128'(kb[0]), 128'h00);
        check("key byte L1", 128'(kb[1]), 128'h00);
        check("key byte L2", 128'(kb[2]), 128'h01);
        check("key byte L16", 128'(kb[16]), 128'h0f);
        check("key byte after LOAD", 128'(kb[17]), 128'h00);
        check("state byte L2", 128'(sb[2]), 128'h11);
        check("state byte L16", 128'(sb[16]), 128'hff);
        check("state byte after LOAD", 128'(sb[17]), 128'h00);
        tick(1);
        waitValid(200);
        check("result C.1", strm.out_block, C1);
        check("err after op", 128'(err), 128'd0);
        tick(20);
        check("out_block held", strm.out_block, C1);
        check("DONE in_ready/out_valid", 128'({strm.in_ready, strm.out_valid}), 128'b01);
        check("enable cycles per op", 128'(lastEnRun), 128'(17 + PROC + 17));
        takeResult();
        check("after handshake", 128'({strm.out_valid, strm.in_ready, busy}), 128'b010);

        // FIPS-197 B with aes_ready dropping mid-capture
        dropReady = 1'b1;
        sendReq(K2, P2);
        waitValid(200);
        check("result B ready drop", strm.out_block, C2);
        takeResult();
        dropReady = 1'b0;

        // Reset in L8 discards the operation
        ovBefore = ovRises;
        sendReq(K1, P1);
        tick(8);
        check("enable in L8", 128'(aes_enable), 128'd1);
        rst_n = 1'b0;
        tick(1);
        check("reset mid-op", 128'({aes_enable, busy, strm.out_valid, strm.in_ready}), 128'd0);
        rst_n = 1'b1;
        tick(1);
        sendReq(K1, P1);
        waitValid(200);
        check("result after abort", strm.out_block, C1);
        takeResult();
        check("one out_valid after abort", 128'(ovRises - ovBefore), 128'd1);

        // Back-to-back with out_ready held high
        expB2b = '{C1, C2, C1, C2};
        results.delete();
        gapValid = 1'b0;
        minGap = 1000;
        strm.out_ready = 1'b1;
        sendReq(K1, P1);
        sendReq(K2, P2);
        sendReq(K1, P1);
        sendReq(K2, P2);
        n = 0;
        while (results.size() < 4 && n < 200) begin
            tick(1);
            n++;
        end
        tick(5);
        strm.out_ready = 1'b0;
        check("b2b result count", 128'(results.size()), 128'd4);
        for (int i = 0; i < 4; i++)
            if (i < results.size()) check($sformatf("b2b result %0d", i), results[i], expB2b[i]);
        check("b2b enable gap >= 2", 128'(minGap >= 2), 128'd1);

        // Core that never answers
        neverReady = 1'b1;
        ovBefore = ovRises;
        sendReq(K1, P1);
`ifdef AES_HOST_TIMEOUT_EN
        n = 0;
        while (err !== 1'b1 && n < 200) begin
            tick(1);
            n++;
        end
        check("timeout err", 128'(err), 128'd1);
        check("after timeout", 128'({aes_enable, strm.in_ready, strm.out_valid, busy}), 128'b0100);
        @(negedge clk);
        #1;
        check("enable cycles to timeout", 128'(lastEnRun), 128'(17 + TMO));
        neverReady = 1'b0;
        tick(1);
        sendReq(K2, P2);
        waitValid(200);
        check("result with err set", strm.out_block, C2);
        check("err sticky", 128'(err), 128'd1);
        takeResult();
        check("no out_valid from timeout", 128'(ovRises - ovBefore), 128'd1);
`else
        tick(300);
        check("still waiting", 128'({busy, aes_enable, err}), 128'b110);
        check("no out_valid while waiting", 128'(ovRises - ovBefore), 128'd0);
`endif
        neverReady = 1'b0;
        rst_n = 1'b0;
        tick(1);
        rst_n = 1'b1;
        check("err clear after reset", 128'({err, busy}), 128'd0);
        tick(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/aes_stream_host.md
AES_STREAM_HOST -- requirements
Module: aes_stream_host

Interface
- REQ-001: Parameter TIMEOUT_CYCLES, default 255; wait-for-result limit in cycles, used only with AES_HOST_TIMEOUT_EN.
- REQ-002: Single clock, synchronous active-low reset (already decided): clk in 1, rising-edge clock.
- REQ-003: rst_n  in  1  synchronous active-low reset.
- REQ-004: in_valid  in  1  request valid; in_ready  out  1  request accepted when both high.
- REQ-005: in_key  in  128  cipher key; in_block  in  128  plaintext; both sampled on accept.
- REQ-006: out_valid  out  1  result valid; out_ready  in  1  result taken when both high.
- REQ-007: out_block  out  128  ciphertext.
- REQ-008: busy  out  1  high in any state other than IDLE.
- REQ-009: err  out  1  sticky timeout flag.
- REQ-010: aes_enable  out  1; aes_key_byte  out  8; aes_state_byte  out  8; all drive the core.
- REQ-011: aes_state_out_byte  in  8; aes_load  in  1; aes_ready  in  1; all come from the core.

Function
- REQ-012: States are IDLE, LOAD, WAIT, CAPT and DONE; all outputs are registered.
- REQ-013: IDLE: in_ready=1; when in_valid=1, latch key and block, clear byte counter, set aes_enable=1, go to LOAD.
- REQ-014: LOAD lasts 17 cycles, L0..L16, with aes_enable=1.
  - Byte 0 = bits [127:120] of key and block; it is driven in L0 and L1.
  - Byte n (n=1..15) is driven in L(n+1).
  - Then go to WAIT.
- REQ-015: WAIT: aes_ready is honoured only when aes_load=0; the first such cycle with aes_ready=1 is R0; go to CAPT.
- REQ-016: CAPT: capture aes_state_out_byte in the 16 cycles R1..R16, MSB first, into out_block[127-8k -: 8].
- REQ-017: At the end of R16, clear aes_enable, set out_valid=1 and go to DONE.
- REQ-018: If aes_ready drops during R1..R16, the capture still completes at 16 bytes; no early exit.
- REQ-019: DONE: hold out_block and out_valid until out_ready=1, then go to IDLE; in_ready=0 throughout DONE.
- REQ-020: A new request is accepted no earlier than the cycle after the handshake, so aes_enable is low for at least 2 cycles between operations.
- REQ-021: aes_key_byte and aes_state_byte read 0 outside LOAD; aes_enable is high only in LOAD, WAIT and CAPT.
- REQ-022: in_valid is ignored outside IDLE; latched operands are unaffected by input changes.
- REQ-023: End-to-end latency = 17 + core processing + 17 cycles.

Reset
- REQ-024: rst_n=0 at a clock edge forces IDLE and clears the counters.
- REQ-025: Reset values: in_ready=0, out_valid=0, out_block=0, busy=0, err=0, aes_enable=0, aes_key_byte=0, aes_state_byte=0.
- REQ-026: in_ready rises the first cycle after reset is released.
- REQ-027: Reset mid-operation drops aes_enable the next edge and discards partial data; no out_valid is produced.

Configuration
- REQ-028: Macro AES_HOST_TIMEOUT_EN.
  - Defined: a counter runs in WAIT; if it reaches TIMEOUT_CYCLES, set err=1, clear aes_enable and go to IDLE without out_valid.
  - err clears only on reset.
- REQ-029: Without AES_HOST_TIMEOUT_EN, err is tied to 0 and WAIT waits indefinitely.

Verification
- REQ-030: Connect the team AES encryption core. Key 000102030405060708090a0b0c0d0e0f, block 00112233445566778899aabbccddeeff -> out_block 69c4e0d86a7b0432d8cdb78070b4c55a, err=0.
- REQ-031: Byte timing check on the same request: aes_key_byte=00 in L0 and L1, 01 in L2, 0f in L16, 00 after; aes_state_byte=ff in L16.
- REQ-032: Hold out_ready=0 for 20 cycles after out_valid -> out_block stable, in_ready=0. Then pulse out_ready and present key 2b7e151628aed2a6abf7158809cf4f3c, block 3243f6a8885a308d313198a2e0370734 -> 3925841d02dc09fbdc118597196a0b32.
- REQ-033: Assert rst_n=0 in L8 -> next cycle aes_enable=0, busy=0, out_valid=0. A following FIPS-197 request completes correctly.
- REQ-034: With AES_HOST_TIMEOUT_EN and TIMEOUT_CYCLES=40, use a core model that never asserts aes_ready -> err=1 after 40 WAIT cycles, aes_enable=0, in_ready=1, out_valid never asserted.
- REQ-035: Run back-to-back requests with out_ready tied 1 -> aes_enable gap of at least 2 cycles, each result correct, no missed or duplicated outputs.
